// File: rtl/fp_pkg.sv
// Shared single-precision helpers for the calculator FP datapath.
// Holds format constants, the multiplier FSM state type and field slicers
// used by both the iterative multiplier and divider.
package fp_pkg;

  localparam int unsigned MANT_W  = 23;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MANT_W-1:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/sb_mant_shift_add.sv
// Shift-and-add mantissa core: one multiplier bit per clock.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       preload the product register with mb (low half)
//   step       one add/shift iteration
//   ma, mb     mantissas including hidden bit
//   prod       full 2*MW-bit product, valid after MW steps
module sb_mant_shift_add #(
  parameter int unsigned MW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [MW-1:0]   ma,
  input  logic [MW-1:0]   mb,
  output logic [2*MW-1:0] prod
);

  // The architectural register is 2*MW+1 bits wide, but its top bit is
  // always zero after the right shift, so only 2*MW bits are stored.
  logic [2*MW-1:0] p_q, p_d;
  logic [MW:0]     upper;

  always_comb begin
    upper = {1'b0, p_q[2*MW-1:MW]} + (p_q[0] ? {1'b0, ma} : '0);
    p_d   = p_q;
    if (load) begin
      p_d = {{MW{1'b0}}, mb};
    end else if (step) begin
      p_d = {upper, p_q[MW-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign prod = p_q;

endmodule

// File: rtl/sb_fp_multiplier_seq.sv
// Iterative IEEE-754 single-precision multiplier with start/done handshake.
// Truncation rounding, denormals flushed to zero, exp 255 treated as overflow.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               request, sampled only in IDLE
//   a, b                operands (sign, exp[30:23], frac[22:0])
//   busy                high whenever the FSM is not idle
//   done                one-cycle completion pulse
//   result              product, held until the next completion
//   overflow, underflow status, held with result
module sb_fp_multiplier_seq #(
  parameter int unsigned MANT_W = fp_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_pkg::EXP_W,
  parameter int unsigned BIAS   = fp_pkg::BIAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);
  import fp_pkg::*;

  localparam int unsigned MW = MANT_W + 1;
  localparam int unsigned SW = EXP_W + 2;
  localparam logic signed [SW-1:0] BIAS_S   = SW'(BIAS);
  localparam logic signed [SW-1:0] EMAX_S   = SW'(EXP_MAX);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;

  state_e                 state_q, state_d;
  logic [4:0]             step_q, step_d;
  logic                   sign_q, sign_d;
  logic                   zflag_q, zflag_d;
  logic                   iflag_q, iflag_d;
  logic [MW-1:0]          ma_q, ma_d;
  logic signed [SW-1:0]   esum_q, esum_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [31:0]            result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic                   core_load, core_step;
  logic [2*MW-1:0]        prod;
  logic signed [SW-1:0]   e_norm;
  logic [MANT_W-1:0]      frac;

  sb_mant_shift_add #(.MW(MW)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .step (core_step),
    .ma   (ma_q),
    .mb   ({1'b1, fp_frac(b)}),
    .prod (prod)
  );

  // Bits below the truncation point never reach the result.
  logic unused_prod_lo;
  assign unused_prod_lo = ^prod[MW-2:0];

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    sign_d    = sign_q;
    zflag_d   = zflag_q;
    iflag_d   = iflag_q;
    ma_d      = ma_q;
    esum_d    = esum_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    core_load = 1'b0;
    core_step = 1'b0;

    // Product MSB set means the mantissa product is in [2,4): shift by one.
    e_norm = esum_q - BIAS_S + SW'(prod[2*MW-1]);
    frac   = prod[2*MW-1] ? prod[2*MW-2:MW] : prod[2*MW-3:MW-1];

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d   = MUL;
          step_d    = '0;
          busy_d    = 1'b1;
          core_load = 1'b1;
          sign_d    = fp_sign(a) ^ fp_sign(b);
          ma_d      = {1'b1, fp_frac(a)};
          esum_d    = SW'(fp_exp(a)) + SW'(fp_exp(b));
          zflag_d   = (fp_exp(a) == '0) | (fp_exp(b) == '0);
          iflag_d   = (fp_exp(a) == EXP_ONES) | (fp_exp(b) == EXP_ONES);
        end
      end
      MUL: begin
        core_step = 1'b1;
        step_d    = step_q + 5'd1;
        if (step_q == 5'(MW - 1)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        done_d  = 1'b1;
        state_d = DONE;
        if (zflag_q) begin
          result_d = {sign_q, 31'b0};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else if (iflag_q || e_norm >= EMAX_S) begin
          result_d = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
        end else if (e_norm[SW-1] || e_norm == '0) begin
          result_d = {sign_q, 31'b0};
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, e_norm[EXP_W-1:0], frac};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      sign_q   <= 1'b0;
      zflag_q  <= 1'b0;
      iflag_q  <= 1'b0;
      ma_q     <= '0;
      esum_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      sign_q   <= sign_d;
      zflag_q  <= zflag_d;
      iflag_q  <= iflag_d;
      ma_q     <= ma_d;
      esum_q   <= esum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sb_fp_multiplier_seq.sv
module tb_sb_fp_multiplier_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] prev_res = '0;
   logic        prev_ovf = 1'b0;
   logic        prev_unf = 1'b0;

   sb_fp_multiplier_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_mul(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic ov, output logic un);
      logic            s;
      int              ex, ey, e;
      longint unsigned mx, my, p;
      logic [47:0]     p48;
      logic [22:0]     fr;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      ov = 1'b0;
      un = 1'b0;
      if (ex == 0 || ey == 0) begin
         r = {s, 31'b0};
      end else if (ex == 255 || ey == 255) begin
         r  = {s, 8'hFF, 23'b0};
         ov = 1'b1;
      end else begin
         mx  = longint'({1'b1, x[22:0]});
         my  = longint'({1'b1, y[22:0]});
         p   = mx * my;
         p48 = p[47:0];
         e   = ex + ey - 127;
         if (p48[47]) begin
            fr = p48[46:24];
            e  = e + 1;
         end else begin
            fr = p48[45:23];
         end
         if (e >= 255) begin
            r  = {s, 8'hFF, 23'b0};
            ov = 1'b1;
         end else if (e <= 0) begin
            r  = {s, 31'b0};
            un = 1'b1;
         end else begin
            r = {s, 8'(e), fr};
         end
      end
   endtask

   task automatic op(input logic [31:0] ta, input logic [31:0] tb_op, input bit dbl);
      logic [31:0] er;
      logic        eo, eu;
      int          ndone;
      ref_mul(ta, tb_op, er, eo, eu);
      @(negedge clk);
      a = ta; b = tb_op; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom;
      chk("busy_after_start", busy, 1'b1);
      chk("result_held", result, prev_res);
      chk("ovf_held", overflow, prev_ovf);
      chk("unf_held", underflow, prev_unf);
      ndone = 0;
      for (int i = 1; i <= 26; i++) begin
         @(posedge clk); #1;
         start = (dbl && i == 4);
         if (dbl && i == 4) begin
            a = $urandom; b = $urandom;
         end
         if (done) ndone++;
         chk("busy_cycle", busy, (i <= 25));
         chk("done_cycle", done, (i == 25));
         if (i == 25) begin
            chk("result", result, er);
            chk("overflow", overflow, eo);
            chk("underflow", underflow, eu);
         end
      end
      chk("done_count", ndone, 1);
      chk("result_after", result, er);
      prev_res = er;
      prev_ovf = eo;
      prev_unf = eu;
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          seen_done;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 32'h0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_unf", underflow, 1'b0);
      rst = 1'b0;

      op(32'h3FC00000, 32'h40000000, 1'b0);
      op(32'h3FC00000, 32'h3FC00000, 1'b0);
      op(32'hC0400000, 32'h3F000000, 1'b0);
      op(32'h00000000, 32'hC0000000, 1'b0);
      op(32'h7F000000, 32'h7F000000, 1'b0);
      op(32'h00800000, 32'h00800000, 1'b0);
      op(32'h7F800000, 32'h3F800000, 1'b0);
      op(32'h3FC00000, 32'h40000000, 1'b1);
      op(32'h40490FDB, 32'hC02DF854, 1'b0);

      @(negedge clk);
      a = 32'h40400000; b = 32'h40400000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_result", result, 32'h0);
      chk("midrst_ovf", overflow, 1'b0);
      chk("midrst_unf", underflow, 1'b0);
      rst = 1'b0;
      prev_res = '0; prev_ovf = 1'b0; prev_unf = 1'b0;
      seen_done = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("midrst_quiet", seen_done, 1'b0);
      op(32'h40400000, 32'h40400000, 1'b0);

      for (int n = 0; n < 12; n++) begin
         ra = $urandom; rb = $urandom;
         if (n < 8) begin
            ra[30:23] = 8'($urandom_range(90, 165));
            rb[30:23] = 8'($urandom_range(90, 165));
         end
         op(ra, rb, (n % 4) == 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sb_fp_multiplier_seq.md
Name: sb_fp_multiplier_seq

Overview:
Iterative IEEE-754 single-precision multiplier, the companion to the iterative FP divider in the calculator datapath. It shares the divider's 32-bit operand/result format and its truncation rounding. Unlike the divider, which is paced by an external step counter, this block runs its own FSM and uses a start/done handshake. One mantissa bit is processed per clock by shift-and-add.

Parameters:
MANT_W, 23, stored fraction width (the hidden bit is added internally).
EXP_W, 8, exponent field width.
BIAS, 127, exponent bias.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; synchronous, active-high.
start  input  1  one-cycle request; sampled only in IDLE.
a  input  32  operand A (sign, exp[30:23], frac[22:0]).
b  input  32  operand B, same format.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; result and flags valid from this cycle on.
result  output  32  product; held until the next completion.
overflow  output  1  exponent exceeded 254, or an input exponent field was 255; held with result.
underflow  output  1  biased exponent was <= 0 and the product was flushed to zero; held with result.

Behaviour:
- Reset (synchronous, at any time, including mid-operation):
  - state=IDLE.
  - busy, done, result, overflow and underflow all go to 0.
  - Internal registers are cleared; the operation in flight is abandoned.
- States: IDLE -> MUL -> NORM -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1, latch operands and go to MUL with step=0.
  - Latched values: sign = a[31]^b[31]; ma = {1,a[22:0]}; mb = {1,b[22:0]}; esum = a[30:23] + b[30:23] as 10-bit signed.
  - Also latch zflag = (a[30:23]==0)|(b[30:23]==0). Denormals are flushed to zero.
  - Also latch iflag = (a[30:23]==255)|(b[30:23]==255).
- MUL: 24 edges, step 0..23.
  - Product register P is 49 bits; its low 24 bits are preloaded with mb.
  - Each edge: if P[0]=1, add ma to P[48:24]. Then shift P right by one.
  - Leave MUL after step 23.
- NORM: one edge, ordered by priority.
  - zflag: result = {sign, 31'b0}; overflow=0; underflow=0.
  - iflag: result = {sign, 8'hFF, 23'b0}; overflow=1.
  - Otherwise, if P[47]=1: frac = P[46:24]; e = esum - BIAS + 1.
  - Otherwise: frac = P[45:23]; e = esum - BIAS.
  - Truncate the fraction; no rounding.
  - If e >= 255: result = {sign, 8'hFF, 23'b0}; overflow=1.
  - Else if e <= 0: result = {sign, 31'b0}; underflow=1.
  - Else: result = {sign, e[7:0], frac}; both flags 0.
  - Set done=1 and go to DONE.
- DONE: one cycle.
  - done=1 during this cycle.
  - At the next edge: done=0, state=IDLE.
- Latency: start sampled at edge k; result registered and done=1 after edge k+25; busy low again after edge k+26.
- Fixed throughput: one operation per 27 cycles.
- start while busy=1 is ignored; no queuing.
- Operands a and b may change freely after the start edge.
- result and flags are updated only at the NORM edge. They hold across IDLE and across the next MUL phase.
- Exponent arithmetic is 10-bit signed, so esum up to 510 cannot wrap.

Decomposition:
- Shared package fp_pkg holds:
  - constants BIAS, EXP_W, MANT_W, EXP_MAX=255;
  - state enum {IDLE, MUL, NORM, DONE};
  - field-slice helpers for sign, exp and frac, shared with the divider.
- One natural sub-module: sb_mant_shift_add. It is the 24-step shift-and-add mantissa core, with load/step inputs and a 48-bit product output.
- The FSM, exponent logic, normalization and packing stay in the top module.

Test Plan:
- 1.5×2.0: a=0x3FC00000, b=0x40000000, start at edge k -> done high after edge k+25; result=0x40400000; flags 0.
- Normalization carry, 1.5×1.5: a=0x3FC00000, b=0x3FC00000 -> result=0x40100000.
- Sign/zero: a=0xC0400000, b=0x3F000000 -> 0xBFC00000. Then a=0x00000000, b=0xC0000000 -> 0x80000000 with both flags 0.
- Overflow/underflow: 0x7F000000×0x7F000000 -> 0x7F800000 with overflow=1. 0x00800000×0x00800000 -> 0x00000000 with underflow=1.
- Handshake:
  - a second start pulse at edge k+5 is ignored; exactly one done occurs at k+25;
  - busy=1 from after edge k through edge k+26;
  - a new start at edge k+27 is accepted.
- Reset mid-op:
  - rst=1 at edge k+10 -> busy=0, done never asserts, result and flags read 0;
  - a subsequent start completes normally.
